mor1kx_icache_refill: RTL

Bus-side refill engine that sits directly downstream of the instruction cache's refill request and feeds its write port. On a miss it runs a critical-word-first, wrapping burst on the instruction bus. Each returned word goes to the cache as a registered (wradr, wrdat, we) beat. Bus errors are reported as a one-cycle error pulse that returns the cache to idle.

---
 rtl/mor1kx_icache_refill_pkg.sv | 26 ++
 rtl/mor1kx_refill_adrgen.sv | 59 +++++
 rtl/mor1kx_icache_refill.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mor1kx_icache_refill_pkg.sv
// Shared refill definitions: state encoding and line geometry helpers.
// Used by the instruction and data cache refill engines.
package mor1kx_icache_refill_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_BURST = 4'b0010,
    ST_DRAIN = 4'b0100,
    ST_FLUSH = 4'b1000
  } refill_state_e;

  localparam int WORD_LSB = 2;

  function automatic int beats(input int bw);
    return 1 << (bw - WORD_LSB);
  endfunction

  function automatic int word_bits(input int bw);
    return bw - WORD_LSB;
  endfunction

  function automatic int base_bits(input int aw, input int bw);
    return aw - bw;
  endfunction

endpackage

// File: rtl/mor1kx_refill_adrgen.sv
// Refill address generator: line base, wrapping word index, beat count.
// The word index wraps inside the line so the burst is critical-word-first.
module mor1kx_refill_adrgen
  import mor1kx_icache_refill_pkg::*;
#(
  parameter int AW = 32,
  parameter int BW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [AW-1:0] adr_i,
  output logic [AW-1:0] cur_adr_o,
  output logic          last_beat_o
);

  localparam int WB = word_bits(BW);
  localparam int LB = base_bits(AW, BW);

  logic [LB-1:0] base_q, base_d;
  logic [WB-1:0] word_q, word_d;
  logic [WB-1:0] cnt_q, cnt_d;
  logic          unused_adr;

  assign unused_adr = ^adr_i[WORD_LSB-1:0];

  // Load on a new miss, advance one word per accepted beat.
  always_comb begin
    base_d = base_q;
    word_d = word_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      base_d = adr_i[AW-1:BW];
      word_d = adr_i[BW-1:WORD_LSB];
      cnt_d  = '0;
    end else if (step_i) begin
      word_d = word_q + 1'b1;
      cnt_d  = cnt_q + 1'b1;
    end
  end

  // Address generator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      base_q <= base_d;
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cur_adr_o   = {base_q, word_q, 2'b00};
  assign last_beat_o = &cnt_q;

endmodule

// File: rtl/mor1kx_icache_refill.sv
// Instruction cache refill engine: wrapping bus burst into the
// cache write port, with error and abort handling.
module mor1kx_icache_refill
  import mor1kx_icache_refill_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH      = 32,
  parameter int OPTION_ICACHE_BLOCK_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            refill_i,
  input  logic                            refill_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] miss_adr_i,
  output logic [OPTION_OPERAND_WIDTH-1:0] wradr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] wrdat_o,
  output logic                            we_o,
  output logic                            imem_err_o,
  output logic                            busy_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] ibus_adr_o,
  output logic                            ibus_req_o,
  output logic                            ibus_burst_o,
  input  logic                            ibus_ack_i,
  input  logic                            ibus_err_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] ibus_dat_i
);

  localparam int AW = OPTION_OPERAND_WIDTH;

  refill_state_e state_q, state_d;

  logic          load, step;
  logic [AW-1:0] cur_adr;
  logic          last_beat;
  logic          we_q, we_d;
  logic          err_q, err_d;
  logic [AW-1:0] wradr_q, wradr_d;
  logic [AW-1:0] wrdat_q, wrdat_d;

  mor1kx_refill_adrgen #(
    .AW(AW),
    .BW(OPTION_ICACHE_BLOCK_WIDTH)
  ) u_adrgen (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load),
    .step_i     (step),
    .adr_i      (miss_adr_i),
    .cur_adr_o  (cur_adr),
    .last_beat_o(last_beat)
  );

  // Next state, address generator control and write-port next values.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    we_d    = 1'b0;
    err_d   = 1'b0;
    wradr_d = wradr_q;
    wrdat_d = wrdat_q;
    case (state_q)
      ST_IDLE: begin
        if (refill_req_i && refill_i) begin
          load    = 1'b1;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (!refill_i) begin
          // Cache abandoned the refill; finish the open beat silently.
          if (ibus_ack_i || ibus_err_i) state_d = ST_IDLE;
          else                          state_d = ST_FLUSH;
        end else if (ibus_err_i) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (ibus_ack_i) begin
          we_d    = 1'b1;
          wradr_d = cur_adr;
          wrdat_d = ibus_dat_i;
          step    = 1'b1;
          if (last_beat) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!refill_i) state_d = ST_IDLE;
      end
      ST_FLUSH: begin
        if (ibus_ack_i || ibus_err_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Registered cache write port and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      wradr_q <= '0;
      wrdat_q <= '0;
    end else begin
      we_q    <= we_d;
      err_q   <= err_d;
      wradr_q <= wradr_d;
      wrdat_q <= wrdat_d;
    end
  end

  assign ibus_req_o   = (state_q == ST_BURST) || (state_q == ST_FLUSH);
  assign ibus_adr_o   = ibus_req_o ? cur_adr : '0;
  assign ibus_burst_o = (state_q == ST_BURST) && !last_beat;
  assign busy_o       = (state_q != ST_IDLE);
  assign we_o         = we_q;
  assign imem_err_o   = err_q;
  assign wradr_o      = wradr_q;
  assign wrdat_o      = wrdat_q;

endmodule
